// File: rtl/dm_responder.sv
// Data-memory responder: services word read/write requests over valid/ready
// channels against an internal RAM, with programmable wait states and power-up clear.
//
// state | meaning
// CLEAR | zeroing RAM one word per cycle after reset
// IDLE  | ready to accept a request
// WAIT  | counting wait states, operation performed when cnt reaches 0
// RESP  | holding registered response until resp_ready
module dm_responder #(
  parameter int DEPTH   = 3072,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;

  logic [31:0]   mem [DEPTH];

  logic          accept, do_op, clr_last, op_err;
  logic [AW-1:0] op_idx;
  logic [31:0]   cur_word, merged;

  assign clr_last = (clr_idx == AW'(DEPTH - 1));
  assign op_err   = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
  assign op_idx   = lat_addr[AW+1:2];
  assign cur_word = mem[op_idx];
  assign busy     = (state != IDLE);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : cur_word[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    do_op     = 1'b0;
    case (state)
      CLEAR: if (clr_last) state_nxt = IDLE;
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_op     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= 4'(LATENCY);
      end
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (do_op) begin
        resp_valid <= 1'b1;
        resp_err   <= op_err;
        resp_rdata <= op_err ? 32'd0 : (lat_we ? merged : cur_word);
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

  // RAM has no reset; CLEAR zeroes it and state is held in CLEAR while reset is low
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_idx] <= 32'd0;
    else if (do_op && lat_we && !op_err) mem[op_idx] <= merged;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (DEPTH=16) with LATENCY 1, 0 and 3.
module tb_dm_responder;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_be     [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        busy       [3];

  int n_tests = 0;
  int n_fail  = 0;

  dm_responder #(.DEPTH(16), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0]));

  dm_responder #(.DEPTH(16), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1]));

  dm_responder #(.DEPTH(16), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!req_ready[k] && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready[k]) check("ready_timeout", 32'(req_ready[k]), 32'd1);
  endtask

  // one full transaction; lat is the number of edges from acceptance to resp_valid
  task automatic xact(input int k, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat);
    wait_ready(k);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_be[k]    = be;
    tick();
    req_valid[k] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (resp_valid[k]) break;
    end
    if (!resp_valid[k]) check("resp_timeout", 32'(resp_valid[k]), 32'd1);
    rd = resp_rdata[k];
    er = resp_err[k];
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
  endtask

  task automatic rd_chk(input int k, input string tag, input logic [31:0] addr,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic er;
    int lat;
    xact(k, 1'b0, addr, 32'd0, 4'h0, rd, er, lat);
    check({tag, "_rdata"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic clear_len(input int k, input string tag);
    int n = 0;
    int busy_bad = 0;
    while (!req_ready[k] && n < 100) begin
      if (!busy[k]) busy_bad++;
      tick();
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'd16);
    check({tag, "_busy_low"}, 32'(busy_bad), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'd0;
      req_wdata[k] = 32'd0; req_be[k] = 4'h0; resp_ready[k] = 1'b0;
    end
    #1;
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_rdata", resp_rdata[0], 32'd0);
    check("rst_err", 32'(resp_err[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd1);
    tick();
    tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    clear_len(0, "clear0");
    for (int i = 0; i < 16; i++) rd_chk(0, "clear_word", 32'(i * 4), 32'd0);

    // basic write/read, LATENCY=1
    xact(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_rdata", rd, 32'hDEADBEEF);
    check("wr_err", 32'(er), 32'd0);
    rd_chk(0, "rd8", 32'h8, 32'hDEADBEEF);

    xact(0, 1'b1, 32'h8, 32'h11223344, 4'b0101, rd, er, lat);
    check("be_rdata", rd, 32'hDE22BE44);
    rd_chk(0, "be_rd", 32'h8, 32'hDE22BE44);
    xact(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("be0_rdata", rd, 32'hDE22BE44);
    check("be0_err", 32'(er), 32'd0);
    rd_chk(0, "be0_rd", 32'h8, 32'hDE22BE44);

    // error cases
    xact(0, 1'b0, 32'h2, 32'd0, 4'h0, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    xact(0, 1'b1, 32'h9, 32'hAAAAAAAA, 4'hF, rd, er, lat);
    check("mis_wr_err", 32'(er), 32'd1);
    rd_chk(0, "mis_wr_rd", 32'h8, 32'hDE22BE44);
    xact(0, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF, rd, er, lat);
    xact(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    rd_chk(0, "oor_last", 32'h3C, 32'h0BADF00D);
    rd_chk(0, "oor_wrap0", 32'h0, 32'd0);
    xact(0, 1'b0, 32'hFFFFFFFC, 32'd0, 4'h0, rd, er, lat);
    check("oor_hi_err", 32'(er), 32'd1);

    // LATENCY=0 with backpressure
    xact(1, 1'b1, 32'h10, 32'h12345678, 4'hF, rd, er, lat);
    check("l0_lat", 32'(lat), 32'd1);
    wait_ready(1);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10;
    tick();
    req_valid[1] = 1'b0;
    tick();
    check("l0_valid", 32'(resp_valid[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp_valid[1]), 32'd1);
      check("bp_rdata", resp_rdata[1], 32'h12345678);
      check("bp_err", 32'(resp_err[1]), 32'd0);
      check("bp_req_ready", 32'(req_ready[1]), 32'd0);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h10;
      req_wdata[1] = 32'd0; req_be[1] = 4'hF;
      tick();
    end
    req_valid[1] = 1'b0;
    check("bp_valid_end", 32'(resp_valid[1]), 32'd1);
    resp_ready[1] = 1'b1;
    tick();
    resp_ready[1] = 1'b0;
    check("hs_req_ready", 32'(req_ready[1]), 32'd1);
    check("hs_valid", 32'(resp_valid[1]), 32'd0);
    check("hs_rdata_kept", resp_rdata[1], 32'h12345678);
    rd_chk(1, "bp_ignored", 32'h10, 32'h12345678);

    // reset during WAIT, LATENCY=3
    xact(2, 1'b1, 32'h8, 32'h00000055, 4'hF, rd, er, lat);
    check("l3_lat", 32'(lat), 32'd4);
    check("l3_rdata", rd, 32'h00000055);
    wait_ready(2);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h4;
    req_wdata[2] = 32'hCAFEF00D; req_be[2] = 4'hF;
    tick();
    req_valid[2] = 1'b0;
    tick();
    check("mid_busy_wait", 32'(busy[2]), 32'd1);
    #2;
    rst[2] = 1'b0;
    #1;
    check("mid_rst_rdata", resp_rdata[2], 32'd0);
    check("mid_rst_valid", 32'(resp_valid[2]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[2]), 32'd0);
    check("mid_rst_busy", 32'(busy[2]), 32'd1);
    tick();
    tick();
    rst[2] = 1'b1;
    clear_len(2, "clear2");
    rd_chk(2, "mid_rd4", 32'h4, 32'd0);
    rd_chk(2, "mid_rd8", 32'h8, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the CPU's data accesses (lw/sw path).
- The CPU core issues word requests over a valid/ready request channel. This block services them against an internal word-addressed RAM, with a configurable wait-state count, and returns a registered response on a valid/ready response channel.
- Replaces the zero-latency DM when the core moves to a handshaked memory interface.
- Owns power-up clearing of data memory.

Parameters:
DEPTH, 3072, number of 32-bit words; word index range 0..DEPTH-1.
LATENCY, 1, wait cycles inserted between request acceptance and memory operation; legal 0..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0); one clock domain
req_valid  input  1  request present
req_ready  output  1  responder can accept request
req_we  input  1  1=write (sw), 0=read (lw)
req_addr  input  32  byte address
req_wdata  input  32  write data
req_be  input  4  byte enables for writes; bit i covers bits [8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  initiator accepts response
resp_rdata  output  32  read data, or post-write word for writes; 0 on error
resp_err  output  1  1=request rejected (misaligned or out of range)
busy  output  1  1 when state != IDLE

Behaviour:
- Reset (reset=0, async):
  - state=CLEAR, clr_idx=0.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=1.
  - Any in-flight request is discarded; an unperformed write never lands.
- Operation starts on the first rising edge after reset releases. Release is assumed synchronous to clk.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Each cycle writes mem[clr_idx]=0 and increments clr_idx.
  - After writing index DEPTH-1, goes to IDLE (exactly DEPTH cycles).
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latches we/addr/wdata/be, loads cnt=LATENCY and goes to WAIT.
  - req_ready is combinational from state only, never from req_valid.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrements cnt.
  - If cnt==0, on that edge performs the operation, registers resp_rdata/resp_err, sets resp_valid=1 and goes to RESP.
  - Timing: with acceptance at edge E0, resp_valid rises at edge E0+LATENCY+1.
- Operation rules:
  - word index = addr[31:2].
  - Error if addr[1:0]!=0 or addr[31:2]>=DEPTH. Then resp_err=1, resp_rdata=0, memory untouched.
  - Read: resp_rdata=mem[idx]; be ignored.
  - Write: each lane with be[i]=1 is replaced by wdata lane i; other lanes are kept. resp_rdata is the merged word.
  - we=1 with be=0000 is legal: no change, resp_err=0, rdata=current word.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable while resp_ready=0.
  - On an edge with resp_ready=1, goes to IDLE with resp_valid=0. resp_rdata/resp_err keep their last values.
  - req_ready=0; only one request is outstanding at a time.
  - Next acceptance is possible no earlier than the edge after the response handshake.
- resp_ready asserted in states other than RESP has no effect. req_valid outside IDLE is ignored and never latched.
- Memory contents change only in CLEAR or at the operation edge of a write. There is no combinational read path to outputs.

Test Plan:
- Reset clear (DEPTH=16, LATENCY=1): reset low 2 cycles, release. Required: busy=1 and req_ready=0 for 16 cycles, then req_ready=1; reads of every word return 0x00000000, err=0.
- Basic write/read, LATENCY=1:
  - Write addr=0x00000008, wdata=0xDEADBEEF, be=1111, accepted at E0. Required: resp_valid at E0+2, rdata=0xDEADBEEF, err=0.
  - Then read 0x8. Required: 0xDEADBEEF.
- Byte enables: word 0x8 = 0xDEADBEEF; write wdata=0x11223344, be=0101. Required: resp_rdata=0xDE22BE44; a subsequent read returns the same.
- Errors:
  - Read 0x00000002. Required: err=1, rdata=0.
  - Write addr=DEPTH*4 with be=1111. Required: err=1; reading word DEPTH-1 shows it unchanged.
- Backpressure and LATENCY=0:
  - Read with resp_ready=0 for 5 cycles. Required: resp_valid, rdata and err stable; req_ready=0; req_valid pulses are ignored.
  - After handshake, req_ready=1 the next cycle. resp_valid rises at E0+1.
- Reset mid-operation: accept a write to 0x4 (LATENCY=3); drop reset during WAIT. Required: outputs go to reset values immediately, CLEAR reruns, and a read of 0x4 returns 0.
